// File: rtl/frame_ring_allocator.sv
// frame_ring_allocator
//   Allocates frame slots for N_CH channels. Each channel has N_FRAMES slots
//   and one writer slot, one reader slot and a queue of completed frames
//   between them. Requests of the form {channel, role, offset} are turned
//   into compact memory addresses. A start-of-frame (sof) request first
//   moves that role to a new slot. The queue is updated either in LATEST
//   mode (MODE=0) or in FIFO mode (MODE=1).
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   req_*               request channel with valid/ready handshake
//   flush_valid/_ch     returns one channel to its reset allocation
//   rsp_*               registered response, held while rsp_ready is low
//   ready_cnt           queued completed frames per channel, 3 bits each
module frame_ring_allocator #(
  parameter int N_CH     = 3,
  parameter int N_FRAMES = 3,
  parameter int MODE     = 0,
  parameter int ADDR_W   = 19,
  parameter int OFF_W    = 17,
  parameter logic [N_CH*ADDR_W-1:0] CH_BASE     = {19'h62030, 19'h62000, 19'h02000},
  parameter logic [N_CH*5-1:0]      CH_FRAME_AW = {5'd4, 5'd4, 5'd17},
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CH_W-1:0]   req_ch,
  input  logic              req_role,
  input  logic              req_sof,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic              flush_valid,
  input  logic [CH_W-1:0]   flush_ch,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [2:0]        rsp_idx,
  output logic              rsp_stale,
  output logic              rsp_drop,
  output logic              rsp_err,
  output logic [N_CH*3-1:0] ready_cnt
);

  localparam int QD = N_FRAMES - 2;

  logic [2:0] wr_slot_r [N_CH];
  logic [2:0] rd_slot_r [N_CH];
  logic [2:0] q_r       [N_CH][QD];
  logic [2:0] qcnt_r    [N_CH];

  logic              accept_s;
  logic              ch_ok_s;
  logic [2:0]        cur_w_s, cur_r_s, cur_cnt_s;
  logic [2:0]        cur_q_s [QD];
  logic [2:0]        nxt_w_s, nxt_r_s, nxt_cnt_s;
  logic [2:0]        nxt_q_s [QD];
  logic              claim_s, drop_s, stale_s;
  logic [7:0]        busy_s;
  logic [2:0]        free_idx_s;
  logic [2:0]        idx_s;
  logic [4:0]        aw_s;
  logic [ADDR_W-1:0] base_s, mask_s, addr_s;

  assign req_ready = !rsp_valid | rsp_ready;
  assign accept_s  = req_valid & req_ready;

  // Select the requested channel's state, flush it if needed, apply the sof update and translate
  always_comb begin
    ch_ok_s   = (32'(req_ch) < N_CH);
    cur_w_s   = 3'd0;
    cur_r_s   = 3'd1;
    cur_cnt_s = 3'd0;
    aw_s      = 5'd0;
    base_s    = '0;
    for (int i = 0; i < QD; i++) cur_q_s[i] = 3'd0;
    for (int c = 0; c < N_CH; c++) begin
      if (req_ch == CH_W'(c)) begin
        cur_w_s   = wr_slot_r[c];
        cur_r_s   = rd_slot_r[c];
        cur_cnt_s = qcnt_r[c];
        for (int i = 0; i < QD; i++) cur_q_s[i] = q_r[c][i];
        aw_s      = CH_FRAME_AW[c*5 +: 5];
        base_s    = CH_BASE[c*ADDR_W +: ADDR_W];
      end else begin
        aw_s = aw_s;
      end
    end
    // A flush on the same channel is resolved before the request
    if (flush_valid && (flush_ch == req_ch)) begin
      cur_w_s   = 3'd0;
      cur_r_s   = 3'd1;
      cur_cnt_s = 3'd0;
      for (int i = 0; i < QD; i++) cur_q_s[i] = 3'd0;
    end else begin
      cur_cnt_s = cur_cnt_s;
    end

    nxt_w_s   = cur_w_s;
    nxt_r_s   = cur_r_s;
    nxt_cnt_s = cur_cnt_s;
    for (int i = 0; i < QD; i++) nxt_q_s[i] = cur_q_s[i];
    claim_s = 1'b0;
    drop_s  = 1'b0;
    stale_s = 1'b0;

    if (req_sof && ch_ok_s) begin
      if (!req_role) begin
        if (cur_cnt_s == 3'(QD)) begin
          drop_s = 1'b1;
          if (MODE == 32'd0) begin
            // Oldest queued frame is discarded to make room for the new one
            for (int i = 0; i < QD - 1; i++) nxt_q_s[i] = cur_q_s[i+1];
            nxt_q_s[QD-1] = cur_w_s;
            claim_s = 1'b1;
          end else begin
            claim_s = 1'b0;
          end
        end else begin
          for (int i = 0; i < QD; i++) begin
            if (3'(i) == cur_cnt_s) nxt_q_s[i] = cur_w_s;
            else                    nxt_q_s[i] = nxt_q_s[i];
          end
          nxt_cnt_s = cur_cnt_s + 3'd1;
          claim_s   = 1'b1;
        end
      end else begin
        if (cur_cnt_s == 3'd0) begin
          stale_s = 1'b1;
        end else if (MODE == 32'd0) begin
          // Newest frame wins; everything older returns to the free pool
          for (int i = 0; i < QD; i++) begin
            if (3'(i) == cur_cnt_s - 3'd1) nxt_r_s = cur_q_s[i];
            else                           nxt_r_s = nxt_r_s;
          end
          nxt_cnt_s = 3'd0;
        end else begin
          nxt_r_s = cur_q_s[0];
          for (int i = 0; i < QD - 1; i++) nxt_q_s[i] = cur_q_s[i+1];
          nxt_cnt_s = cur_cnt_s - 3'd1;
        end
      end
    end else begin
      claim_s = 1'b0;
    end

    // Lowest slot held by neither the reader nor the queue; the old writer
    // slot is already in the queue whenever a claim happens.
    busy_s = 8'd0;
    busy_s[nxt_r_s] = 1'b1;
    for (int i = 0; i < QD; i++) begin
      if (3'(i) < nxt_cnt_s) busy_s[nxt_q_s[i]] = 1'b1;
      else                   busy_s = busy_s;
    end
    free_idx_s = 3'd0;
    for (int s = N_FRAMES - 1; s >= 0; s--) begin
      if (!busy_s[s]) free_idx_s = 3'(s);
      else            free_idx_s = free_idx_s;
    end
    if (claim_s) nxt_w_s = free_idx_s;
    else         nxt_w_s = nxt_w_s;

    idx_s  = req_role ? nxt_r_s : nxt_w_s;
    mask_s = (ADDR_W'(1) << aw_s) - ADDR_W'(1);
    addr_s = base_s + (ADDR_W'(idx_s) << aw_s) + (ADDR_W'(req_offset) & mask_s);
  end

  // Per-channel allocation state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        wr_slot_r[c] <= 3'd0;
        rd_slot_r[c] <= 3'd1;
        qcnt_r[c]    <= 3'd0;
        for (int i = 0; i < QD; i++) q_r[c][i] <= 3'd0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (accept_s && ch_ok_s && (req_ch == CH_W'(c))) begin
          wr_slot_r[c] <= nxt_w_s;
          rd_slot_r[c] <= nxt_r_s;
          qcnt_r[c]    <= nxt_cnt_s;
          for (int i = 0; i < QD; i++) q_r[c][i] <= nxt_q_s[i];
        end else if (flush_valid && (flush_ch == CH_W'(c))) begin
          wr_slot_r[c] <= 3'd0;
          rd_slot_r[c] <= 3'd1;
          qcnt_r[c]    <= 3'd0;
          for (int i = 0; i < QD; i++) q_r[c][i] <= 3'd0;
        end
      end
    end
  end

  // Response register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_idx   <= 3'd0;
      rsp_stale <= 1'b0;
      rsp_drop  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept_s) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= ch_ok_s ? addr_s : '0;
      rsp_idx   <= ch_ok_s ? idx_s : 3'd0;
      rsp_stale <= stale_s;
      rsp_drop  <= drop_s;
      rsp_err   <= !ch_ok_s;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Queue depth per channel, packed ch0 in the LSBs
  always_comb begin
    ready_cnt = '0;
    for (int c = 0; c < N_CH; c++) ready_cnt[c*3 +: 3] = qcnt_r[c];
  end

endmodule

// File: tb/tb_frame_ring_allocator.sv
module tb_frame_ring_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_role, req_sof, flush_valid, rsp_ready;
  logic [1:0]  req_ch, flush_ch;
  logic [16:0] req_offset;

  logic        o_req_ready [2];
  logic        o_valid     [2];
  logic [18:0] o_addr      [2];
  logic [2:0]  o_idx       [2];
  logic        o_stale     [2];
  logic        o_drop      [2];
  logic        o_err       [2];
  logic [8:0]  o_rc        [2];

  int total = 0;
  int bad   = 0;

  // Reference model: dut0 = LATEST with 3 frames, dut1 = FIFO with 4 frames
  int mode_k [2] = '{0, 1};
  int nf_k   [2] = '{3, 4};
  int base_c [3] = '{32'h02000, 32'h62000, 32'h62030};
  int aw_c   [3] = '{17, 4, 4};
  int m_w [2][3];
  int m_r [2][3];
  int m_q [2][3][$];
  int e_addr [2];
  int e_idx  [2];
  int e_st   [2];
  int e_dr   [2];
  int e_er   [2];

  always #5 clk = ~clk;

  frame_ring_allocator #(.MODE(0), .N_FRAMES(3)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_req_ready[0]),
    .req_ch(req_ch), .req_role(req_role), .req_sof(req_sof), .req_offset(req_offset),
    .flush_valid(flush_valid), .flush_ch(flush_ch), .rsp_valid(o_valid[0]),
    .rsp_ready(rsp_ready), .rsp_addr(o_addr[0]), .rsp_idx(o_idx[0]),
    .rsp_stale(o_stale[0]), .rsp_drop(o_drop[0]), .rsp_err(o_err[0]), .ready_cnt(o_rc[0])
  );

  frame_ring_allocator #(.MODE(1), .N_FRAMES(4)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_req_ready[1]),
    .req_ch(req_ch), .req_role(req_role), .req_sof(req_sof), .req_offset(req_offset),
    .flush_valid(flush_valid), .flush_ch(flush_ch), .rsp_valid(o_valid[1]),
    .rsp_ready(rsp_ready), .rsp_addr(o_addr[1]), .rsp_idx(o_idx[1]),
    .rsp_stale(o_stale[1]), .rsp_drop(o_drop[1]), .rsp_err(o_err[1]), .ready_cnt(o_rc[1])
  );

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset_ch(input int k, input int c);
    m_w[k][c] = 0;
    m_r[k][c] = 1;
    m_q[k][c].delete();
  endtask

  task automatic model_reset_all();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 3; c++) model_reset_ch(k, c);
  endtask

  function automatic int lowest_free(input int k, input int c);
    for (int s = 0; s < nf_k[k]; s++) begin
      bit used = (s == m_r[k][c]);
      foreach (m_q[k][c][i]) if (m_q[k][c][i] == s) used = 1'b1;
      if (!used) return s;
    end
    return -1;
  endfunction

  function automatic int exp_rc(input int k);
    return m_q[k][0].size() + (m_q[k][1].size() << 3) + (m_q[k][2].size() << 6);
  endfunction

  task automatic model_req(input int k, input int ch, input bit role, input bit sof, input int off);
    e_st[k] = 0; e_dr[k] = 0; e_er[k] = 0;
    if (ch >= 3) begin
      e_er[k] = 1; e_addr[k] = 0; e_idx[k] = 0;
      return;
    end
    if (sof && !role) begin
      if (m_q[k][ch].size() == nf_k[k] - 2) begin
        e_dr[k] = 1;
        if (mode_k[k] == 0) begin
          void'(m_q[k][ch].pop_front());
          m_q[k][ch].push_back(m_w[k][ch]);
          m_w[k][ch] = lowest_free(k, ch);
        end
      end else begin
        m_q[k][ch].push_back(m_w[k][ch]);
        m_w[k][ch] = lowest_free(k, ch);
      end
    end else if (sof && role) begin
      if (m_q[k][ch].size() == 0) e_st[k] = 1;
      else if (mode_k[k] == 0) begin
        m_r[k][ch] = m_q[k][ch][$];
        m_q[k][ch].delete();
      end else begin
        m_r[k][ch] = m_q[k][ch].pop_front();
      end
    end
    e_idx[k]  = role ? m_r[k][ch] : m_w[k][ch];
    e_addr[k] = (base_c[ch] + (e_idx[k] << aw_c[ch]) + (off & ((1 << aw_c[ch]) - 1))) & 32'h7FFFF;
  endtask

  // One accepted request (with optional flush), checked on both DUTs
  task automatic step(input int ch, input bit role, input bit sof, input int off, input bit fv, input int fc);
    req_valid   = 1'b1;
    req_ch      = 2'(ch);
    req_role    = role;
    req_sof     = sof;
    req_offset  = 17'(off);
    flush_valid = fv;
    flush_ch    = 2'(fc);
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    flush_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (fv && fc < 3) model_reset_ch(k, fc);
      model_req(k, ch, role, sof, off & 32'h1FFFF);
      check("valid", k, 32'(o_valid[k]), 32'd1);
      check("addr",  k, 32'(o_addr[k]),  e_addr[k]);
      check("idx",   k, 32'(o_idx[k]),   e_idx[k]);
      check("stale", k, 32'(o_stale[k]), e_st[k]);
      check("drop",  k, 32'(o_drop[k]),  e_dr[k]);
      check("err",   k, 32'(o_err[k]),   e_er[k]);
      check("ready_cnt", k, 32'(o_rc[k]), exp_rc(k));
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_ch = 2'd0; req_role = 1'b0; req_sof = 1'b0;
    req_offset = 17'd0; flush_valid = 1'b0; flush_ch = 2'd0; rsp_ready = 1'b1;
    model_reset_all();
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", k, 32'(o_valid[k]), 32'd0);
      check("rst_addr",  k, 32'(o_addr[k]),  32'd0);
      check("rst_rc",    k, 32'(o_rc[k]),    32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Plain translation for writer and reader
    step(0, 0, 0, 32'h10, 0, 0);
    check("t1_w_addr", 0, 32'(o_addr[0]), 32'h02010);
    step(0, 1, 0, 32'h10, 0, 0);
    check("t1_r_addr", 0, 32'(o_addr[0]), 32'h22010);
    // Writer sof then reader sof
    step(0, 0, 1, 0, 0, 0);
    check("t2_w_addr", 0, 32'(o_addr[0]), 32'h42000);
    step(0, 1, 1, 0, 0, 0);
    check("t2_r_idx", 0, 32'(o_idx[0]), 32'd0);
    // Reader sof on an empty queue
    step(1, 1, 1, 0, 0, 0);
    check("t3_addr", 0, 32'(o_addr[0]), 32'h62010);
    check("t3_stale", 0, 32'(o_stale[0]), 32'd1);
    // LATEST overflow, flush ch0 first through a ch1 request
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("t4_idx", 0, 32'(o_idx[0]), 32'd0);
    check("t4_drop", 0, 32'(o_drop[0]), 32'd1);
    step(0, 1, 1, 0, 0, 0);
    check("t4_r_idx", 0, 32'(o_idx[0]), 32'd2);
    // FIFO overflow sequence on dut1
    step(2, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    check("t5_idx_a", 1, 32'(o_idx[1]), 32'd2);
    step(0, 0, 1, 0, 0, 0);
    check("t5_idx_b", 1, 32'(o_idx[1]), 32'd3);
    step(0, 0, 1, 0, 0, 0);
    check("t5_idx_c", 1, 32'(o_idx[1]), 32'd3);
    check("t5_drop", 1, 32'(o_drop[1]), 32'd1);
    step(0, 1, 1, 0, 0, 0);
    check("t5_r_a", 1, 32'(o_idx[1]), 32'd0);
    step(0, 1, 1, 0, 0, 0);
    check("t5_r_b", 1, 32'(o_idx[1]), 32'd2);

    // Stall: response held, request not accepted
    step(2, 0, 0, 5, 0, 0);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_ch = 2'd2; req_role = 1'b0; req_sof = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        check("stall_ready", k, 32'(o_req_ready[k]), 32'd0);
        check("stall_valid", k, 32'(o_valid[k]), 32'd1);
        check("stall_addr",  k, 32'(o_addr[k]),  e_addr[k]);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check("drain_valid", k, 32'(o_valid[k]), 32'd0);
    // Flush and writer sof on the same channel and cycle
    step(0, 0, 1, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      check("fl_idx", k, 32'(o_idx[k]), 32'd2);
      check("fl_drop", k, 32'(o_drop[k]), 32'd0);
    end
    // Asynchronous reset in the middle of a stall
    step(1, 0, 1, 0, 0, 0);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_reset_all();
    for (int k = 0; k < 2; k++) begin
      check("arst_valid", k, 32'(o_valid[k]), 32'd0);
      check("arst_rc", k, 32'(o_rc[k]), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           int'($urandom & 32'h1FFFF), ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
